// File: rtl/modbus_defs.sv
// Shared definitions for the Modbus receive sequencer and CRC engine.
// Byte indices refer to the 56-bit frame, first wire byte in [55:48].
package modbus_defs;

  typedef enum logic [1:0] {
    ST_ARM,
    ST_CRC,
    ST_CHECK,
    ST_HOLD
  } mb_state_e;

  localparam logic [15:0] MB_CRC_INIT = 16'hFFFF;
  localparam logic [15:0] MB_CRC_POLY = 16'hA001;

  localparam int MB_ADDR_HI = 55;
  localparam int MB_FUNC_HI = 47;
  localparam int MB_REGH_HI = 39;
  localparam int MB_REGL_HI = 31;
  localparam int MB_VAL_HI  = 23;
  localparam int MB_CRCL_HI = 15;
  localparam int MB_CRCH_HI = 7;

  localparam logic [5:0] MB_BIT_LAST = 6'd39;

  function automatic logic [15:0] mb_crc_step(
    input logic [15:0] crc,
    input logic        b
  );
    logic [15:0] c;
    c = crc ^ {15'd0, b};
    return (c >> 1) ^ (c[0] ? MB_CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/modbus_crc16_serial.sv
// Bit-serial CRC-16/MODBUS, one bit per step cycle, LSB first.
// Shared between the receive and transmit paths.
module modbus_crc16_serial
  import modbus_defs::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        bit_in,
  input  logic        step,
  output logic [15:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= MB_CRC_INIT;
    end else if (clear) begin
      crc <= MB_CRC_INIT;
    end else if (step) begin
      crc <= mb_crc_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/modbus_frame_ctrl.sv
// Modbus 7-byte receive sequencer: CRC check, address filter, valid/ack.
// Define MODBUS_BROADCAST_EN to accept ADDR=0 as a broadcast frame.
module modbus_frame_ctrl
  import modbus_defs::*;
#(
  parameter logic [7:0] SLAVE_ADDR = 8'h01,
  parameter int         CNT_W      = 8
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             RX_Done_Sig,
  input  logic [55:0]      RX_Data,
  output logic             RX_En_Sig,
  output logic             Frame_Valid,
  input  logic             Frame_Ack,
  output logic [7:0]       Frame_Func,
  output logic [15:0]      Frame_Reg,
  output logic [7:0]       Frame_Value,
  output logic             Frame_Bcast,
  output logic [CNT_W-1:0] Crc_Err_Cnt,
  output logic [CNT_W-1:0] Drop_Cnt
);

  mb_state_e   state;
  logic [55:0] frame_q;
  logic [5:0]  bit_cnt;
  logic [15:0] crc;
  logic [7:0]  cur_byte;
  logic        crc_clear;
  logic        crc_step;
  logic        crc_bit;
  logic        crc_ok;
  logic        is_bcast;
  logic        addr_hit;

  assign crc_clear = (state == ST_ARM) && RX_Done_Sig;
  assign crc_step  = (state == ST_CRC);

  always_comb begin
    cur_byte = 8'h00;
    unique case (bit_cnt[5:3])
      3'd0:    cur_byte = frame_q[MB_ADDR_HI -: 8];
      3'd1:    cur_byte = frame_q[MB_FUNC_HI -: 8];
      3'd2:    cur_byte = frame_q[MB_REGH_HI -: 8];
      3'd3:    cur_byte = frame_q[MB_REGL_HI -: 8];
      3'd4:    cur_byte = frame_q[MB_VAL_HI -: 8];
      default: cur_byte = 8'h00;
    endcase
  end

  assign crc_bit = cur_byte[bit_cnt[2:0]];

  modbus_crc16_serial u_crc (
    .clk    (CLK),
    .rst_n  (RSTn),
    .clear  (crc_clear),
    .bit_in (crc_bit),
    .step   (crc_step),
    .crc    (crc)
  );

  assign crc_ok = crc == {frame_q[MB_CRCH_HI -: 8],
                          frame_q[MB_CRCL_HI -: 8]};

`ifdef MODBUS_BROADCAST_EN
  assign is_bcast = frame_q[MB_ADDR_HI -: 8] == 8'h00;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      Frame_Bcast <= 1'b0;
    end else if (state == ST_CHECK && crc_ok && addr_hit) begin
      Frame_Bcast <= is_bcast;
    end
  end
`else
  assign is_bcast    = 1'b0;
  assign Frame_Bcast = 1'b0;
`endif

  assign addr_hit = (frame_q[MB_ADDR_HI -: 8] == SLAVE_ADDR) || is_bcast;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state       <= ST_ARM;
      RX_En_Sig   <= 1'b0;
      frame_q     <= '0;
      bit_cnt     <= '0;
      Frame_Valid <= 1'b0;
      Frame_Func  <= '0;
      Frame_Reg   <= '0;
      Frame_Value <= '0;
      Crc_Err_Cnt <= '0;
      Drop_Cnt    <= '0;
    end else begin
      unique case (state)
        ST_ARM: begin
          RX_En_Sig <= 1'b1;
          if (RX_Done_Sig) begin
            frame_q   <= RX_Data;
            bit_cnt   <= '0;
            RX_En_Sig <= 1'b0;
            state     <= ST_CRC;
          end
        end
        ST_CRC: begin
          bit_cnt <= bit_cnt + 6'd1;
          if (bit_cnt == MB_BIT_LAST) state <= ST_CHECK;
        end
        ST_CHECK: begin
          // Address is only judged once the CRC has vouched for it.
          if (!crc_ok) begin
            if (Crc_Err_Cnt != {CNT_W{1'b1}})
              Crc_Err_Cnt <= Crc_Err_Cnt + 1'b1;
            RX_En_Sig <= 1'b1;
            state     <= ST_ARM;
          end else if (!addr_hit) begin
            if (Drop_Cnt != {CNT_W{1'b1}})
              Drop_Cnt <= Drop_Cnt + 1'b1;
            RX_En_Sig <= 1'b1;
            state     <= ST_ARM;
          end else begin
            Frame_Func  <= frame_q[MB_FUNC_HI -: 8];
            Frame_Reg   <= {frame_q[MB_REGH_HI -: 8],
                            frame_q[MB_REGL_HI -: 8]};
            Frame_Value <= frame_q[MB_VAL_HI -: 8];
            state       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!Frame_Valid) begin
            Frame_Valid <= 1'b1;
          end else if (Frame_Ack) begin
            Frame_Valid <= 1'b0;
            RX_En_Sig   <= 1'b1;
            state       <= ST_ARM;
          end
        end
        default: state <= ST_ARM;
      endcase
    end
  end

endmodule

// File: tb/tb_modbus_frame_ctrl.sv
// Self-checking bench for modbus_frame_ctrl against a frame-level model.
// Honours MODBUS_BROADCAST_EN the same way as the design.
module tb_modbus_frame_ctrl;

`ifdef MODBUS_BROADCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        RX_Done_Sig;
  logic [55:0] RX_Data;
  logic        RX_En_Sig;
  logic        Frame_Valid;
  logic        Frame_Ack;
  logic [7:0]  Frame_Func;
  logic [15:0] Frame_Reg;
  logic [7:0]  Frame_Value;
  logic        Frame_Bcast;
  logic [7:0]  Crc_Err_Cnt;
  logic [7:0]  Drop_Cnt;

  logic        u_clear;
  logic        u_bit;
  logic        u_step;
  logic [15:0] u_crc;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 CLK = ~CLK;

  modbus_frame_ctrl #(.SLAVE_ADDR(8'h01), .CNT_W(8)) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .RX_Done_Sig (RX_Done_Sig),
    .RX_Data     (RX_Data),
    .RX_En_Sig   (RX_En_Sig),
    .Frame_Valid (Frame_Valid),
    .Frame_Ack   (Frame_Ack),
    .Frame_Func  (Frame_Func),
    .Frame_Reg   (Frame_Reg),
    .Frame_Value (Frame_Value),
    .Frame_Bcast (Frame_Bcast),
    .Crc_Err_Cnt (Crc_Err_Cnt),
    .Drop_Cnt    (Drop_Cnt)
  );

  modbus_crc16_serial u_crc16 (
    .clk    (CLK),
    .rst_n  (RSTn),
    .clear  (u_clear),
    .bit_in (u_bit),
    .step   (u_step),
    .crc    (u_crc)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timeout t=%0t", nm, $time);
  endtask

  // Byte-wise reference CRC; byte i of msg sits at msg[71-8i -: 8].
  function automatic logic [15:0] crc_msg(input logic [71:0] msg,
                                          input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {8'h00, msg[71-8*i -: 8]};
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [55:0] mk_frame(
    input logic [7:0] a, input logic [7:0] f, input logic [7:0] rh,
    input logic [7:0] rl, input logic [7:0] v);
    logic [15:0] c;
    c = crc_msg({a, f, rh, rl, v, 32'h0}, 5);
    return {a, f, rh, rl, v, c[7:0], c[15:8]};
  endfunction

  // Frame-level model: phase 0 armed, 1 busy, 2 about to present, 3 held.
  int          m_phase;
  longint      cyc;
  longint      t_dec;
  logic [55:0] m_fr;
  logic        e_en, e_val, e_bc;
  logic [7:0]  e_func, e_value, e_crc, e_drop;
  logic [15:0] e_reg;

  always @(posedge CLK or negedge RSTn) begin
    logic [15:0] c;
    logic        ok, hit;
    if (!RSTn) begin
      m_phase = 0; cyc = 0; t_dec = 0; m_fr = '0;
      e_en = 0; e_val = 0; e_bc = 0;
      e_func = 0; e_value = 0; e_reg = 0;
      e_crc = 0; e_drop = 0;
    end else begin
      cyc++;
      case (m_phase)
        0: begin
          e_en = 1;
          if (RX_Done_Sig) begin
            m_fr = RX_Data; t_dec = cyc + 41;
            m_phase = 1; e_en = 0;
          end
        end
        1: if (cyc == t_dec) begin
          c   = crc_msg({m_fr[55:16], 32'h0}, 5);
          ok  = c == {m_fr[7:0], m_fr[15:8]};
          hit = (m_fr[55:48] == 8'h01) ||
                (BCAST && m_fr[55:48] == 8'h00);
          if (!ok) begin
            if (e_crc != 8'hFF) e_crc++;
            e_en = 1; m_phase = 0;
          end else if (!hit) begin
            if (e_drop != 8'hFF) e_drop++;
            e_en = 1; m_phase = 0;
          end else begin
            e_func = m_fr[47:40]; e_reg = m_fr[39:24];
            e_value = m_fr[23:16];
            e_bc = BCAST && m_fr[55:48] == 8'h00;
            m_phase = 2;
          end
        end
        2: begin e_val = 1; m_phase = 3; end
        3: if (Frame_Ack) begin
          e_val = 0; e_en = 1; m_phase = 0;
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("rx_en", RX_En_Sig, e_en);
      chk("valid", Frame_Valid, e_val);
      chk("func", Frame_Func, e_func);
      chk("reg", Frame_Reg, e_reg);
      chk("value", Frame_Value, e_value);
      chk("bcast", Frame_Bcast, e_bc);
      chk("crc_cnt", Crc_Err_Cnt, e_crc);
      chk("drop_cnt", Drop_Cnt, e_drop);
    end
  end

  task automatic wait_arm();
    int n = 0;
    while (!RX_En_Sig && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (!RX_En_Sig) fail_now("wait_arm");
  endtask

  task automatic send(input logic [55:0] f);
    @(negedge CLK);
    RX_Data = f; RX_Done_Sig = 1'b1;
    @(negedge CLK);
    RX_Done_Sig = 1'b0;
  endtask

  // k counts edges after the capture edge N; k=0 is right after N.
  task automatic watch(input int n, output int v_at, output int en_at);
    v_at = -1; en_at = -1;
    for (int k = 0; k <= n; k++) begin
      if (k > 0) @(negedge CLK);
      if (Frame_Valid && v_at < 0) v_at = k;
      if (RX_En_Sig && en_at < 0) en_at = k;
    end
  endtask

  task automatic ack();
    @(negedge CLK);
    Frame_Ack = 1'b1;
    @(negedge CLK);
    Frame_Ack = 1'b0;
  endtask

  logic [55:0] good, f;
  int          va, ea;
  logic [7:0]  d0;

  initial begin
    RSTn = 1'b0; RX_Done_Sig = 0; RX_Data = '0; Frame_Ack = 0;
    u_clear = 0; u_bit = 0; u_step = 0;
    repeat (3) @(negedge CLK);
    cmp_en = 1'b1;
    chk("rst_en", RX_En_Sig, 1'b0);
    chk("rst_valid", Frame_Valid, 1'b0);
    chk("rst_cnt", Crc_Err_Cnt, 8'h00);
    RSTn = 1'b1;
    @(negedge CLK);
    chk("arm_en", RX_En_Sig, 1'b1);

    chk("model_crc_check", crc_msg(72'h313233343536373839, 9), 16'h4B37);
    chk("model_crc_rd", crc_msg({48'h010300000001, 24'h0}, 6), 16'h0A84);

    // CRC engine on its own: "123456789".
    @(negedge CLK); u_clear = 1;
    @(negedge CLK); u_clear = 0;
    for (int i = 0; i < 9; i++) begin
      d0 = 8'h31 + 8'(i);
      for (int b = 0; b < 8; b++) begin
        u_step = 1; u_bit = d0[b];
        @(negedge CLK);
      end
    end
    u_step = 0;
    chk("unit_crc", u_crc, 16'h4B37);

    // Good frame, latency and payload.
    good = mk_frame(8'h01, 8'h06, 8'h00, 8'h2A, 8'h55);
    wait_arm();
    send(good);
    watch(50, va, ea);
    chk("good_lat", va, 42);
    chk("good_en_low", ea, -1);
    chk("good_func", Frame_Func, 8'h06);
    chk("good_reg", Frame_Reg, 16'h002A);
    chk("good_value", Frame_Value, 8'h55);
    chk("good_cnts", {Crc_Err_Cnt, Drop_Cnt}, 16'h0000);
    ack();
    chk("ack_valid", Frame_Valid, 1'b0);
    chk("ack_en", RX_En_Sig, 1'b1);

    // CRC_LO bit 0 flipped.
    wait_arm();
    send(good ^ 56'h0000_0000_0001_00);
    watch(50, va, ea);
    chk("bad_valid", va, -1);
    chk("bad_rearm", ea, 41);
    chk("bad_cnt", Crc_Err_Cnt, 8'h01);

    // Foreign address, then address 0.
    wait_arm();
    send(mk_frame(8'h02, 8'h03, 8'h12, 8'h34, 8'h77));
    watch(45, va, ea);
    chk("drop_valid", va, -1);
    chk("drop_cnt1", Drop_Cnt, 8'h01);
    wait_arm();
    send(mk_frame(8'h00, 8'h06, 8'h00, 8'h10, 8'hAA));
    watch(45, va, ea);
    if (BCAST) begin
      chk("bc_lat", va, 42);
      chk("bc_flag", Frame_Bcast, 1'b1);
      chk("bc_drop", Drop_Cnt, 8'h01);
      ack();
    end else begin
      chk("bc_valid", va, -1);
      chk("bc_drop", Drop_Cnt, 8'h02);
    end

    // Hold without ack while the line keeps pulsing.
    wait_arm();
    send(mk_frame(8'h01, 8'h10, 8'hBE, 8'hEF, 8'h42));
    watch(45, va, ea);
    chk("hold_lat", va, 42);
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      RX_Done_Sig = ($urandom_range(0, 3) == 0);
      RX_Data = {$urandom, $urandom};
    end
    @(negedge CLK); RX_Done_Sig = 0;
    chk("hold_valid", Frame_Valid, 1'b1);
    chk("hold_reg", Frame_Reg, 16'hBEEF);
    chk("hold_func", Frame_Func, 8'h10);
    chk("hold_en", RX_En_Sig, 1'b0);
    ack();
    chk("hold_ack", Frame_Valid, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      Frame_Ack = ($urandom_range(0, 3) == 0);
      RX_Done_Sig = 0;
      if ($urandom_range(0, 49) == 0 ||
          (RX_En_Sig && $urandom_range(0, 7) == 0)) begin
        case ($urandom_range(0, 3))
          0: d0 = 8'h00;
          1: d0 = 8'h02;
          2: d0 = 8'($urandom);
          default: d0 = 8'h01;
        endcase
        f = mk_frame(d0, 8'($urandom), 8'($urandom),
                     8'($urandom), 8'($urandom));
        if ($urandom_range(0, 2) == 0)
          f = f ^ (56'h1 << $urandom_range(0, 15));
        RX_Data = f; RX_Done_Sig = 1;
      end
    end
    @(negedge CLK);
    RX_Done_Sig = 0; Frame_Ack = 1;
    repeat (60) @(negedge CLK);
    Frame_Ack = 0;

    // Saturate the CRC error counter.
    for (int i = 0; i < 256; i++) begin
      wait_arm();
      send(good ^ 56'h1);
    end
    repeat (42) @(negedge CLK);
    chk("sat_cnt", Crc_Err_Cnt, 8'hFF);

    // Reset while in CRC.
    wait_arm();
    send(good);
    repeat (10) @(negedge CLK);
    #2 RSTn = 1'b0;
    #1;
    chk("mid_rst_out",
        {RX_En_Sig, Frame_Valid, Frame_Func, Frame_Reg,
         Frame_Value, Frame_Bcast, Crc_Err_Cnt, Drop_Cnt}, 64'h0);
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    chk("mid_rst_arm", RX_En_Sig, 1'b1);
    send(good);
    watch(45, va, ea);
    chk("post_rst_lat", va, 42);
    ack();

    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
